// File: rtl/muldiv_pkg.sv
// muldiv_pkg: operation and state encodings shared by the multiply/divide unit.
// Exposes op_e, state_e and small op-classification helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_FINISH = 2'b10
  } state_e;

  function automatic logic op_is_div(op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle of the multiply/divide unit.
// master drives start/op/a/b; slave returns hi/lo/busy/done/div_zero.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add (multiply) or restoring
// shift-subtract (divide). Ports: is_div_i, acc_i/mq_i/opb_i -> acc_o/mq_o.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mq_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mq_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] rem;
  logic             fits;

  // The remainder after a successful subtract is always below the
  // divisor, so the low WIDTH bits of the difference are exact.
  always_comb begin
    sum  = {1'b0, acc_i} + {1'b0, opb_i};
    shl  = {acc_i, mq_i[WIDTH-1]};
    fits = (shl >= {1'b0, opb_i});
    rem  = shl[WIDTH-1:0] - opb_i;
    if (is_div_i) begin
      acc_o = fits ? rem : shl[WIDTH-1:0];
      mq_o  = {mq_i[WIDTH-2:0], fits};
    end else if (mq_i[0]) begin
      acc_o = sum[WIDTH:1];
      mq_o  = {sum[0], mq_i[WIDTH-1:1]};
    end else begin
      acc_o = {1'b0, acc_i[WIDTH-1:1]};
      mq_o  = {acc_i[0], mq_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply and divide, WIDTH+2 edges.
// Ports: clk, reset (sync, active-high), bus (slave: start/op/a/b -> hi/lo/busy/done/div_zero).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FAST_ZERO = 1
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam bit FZ = (FAST_ZERO != 0);

  state_e           state_q, state_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  op_e                op_sel;
  logic               sgn, is_div, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0]   acc_s, mq_s;

  assign op_sel   = op_e'(bus.op);
  assign sgn      = op_is_signed(op_sel);
  assign is_div   = op_is_div(op_sel);
  assign a_neg    = sgn & bus.a[WIDTH-1];
  assign b_neg    = sgn & bus.b[WIDTH-1];
  assign b_zero   = (bus.b == '0);
  assign a_mag    = a_neg ? -bus.a : bus.a;
  assign b_mag    = b_neg ? -bus.b : bus.b;
  assign prod_mag = {acc_q, mq_q};
  assign prod     = neg_lo_q ? -prod_mag : prod_mag;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (div_q),
    .acc_i    (acc_q),
    .mq_i     (mq_q),
    .opb_i    (opb_q),
    .acc_o    (acc_s),
    .mq_o     (mq_s)
  );

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    acc_d      = acc_q;
    mq_d       = mq_q;
    opb_d      = opb_q;
    cnt_d      = cnt_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    unique case (state_q)
      S_IDLE: begin
        // The done cycle is still IDLE; a start seen there is dropped.
        if (bus.start && !done_q) begin
          state_d    = (FZ && is_div && b_zero) ? S_FINISH : S_RUN;
          div_d      = is_div;
          acc_d      = '0;
          mq_d       = is_div ? a_mag : b_mag;
          opb_d      = is_div ? b_mag : a_mag;
          cnt_d      = '0;
          dz_d       = is_div & b_zero;
          // A zero divisor keeps the all-ones quotient unnegated.
          neg_lo_d   = (a_neg ^ b_neg) & ~(is_div & b_zero);
          neg_hi_d   = is_div & a_neg;
          div_zero_d = 1'b0;
        end
      end
      S_RUN: begin
        acc_d = acc_s;
        mq_d  = mq_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d    = S_IDLE;
        done_d     = 1'b1;
        div_zero_d = dz_q;
        if (!(FZ && dz_q)) begin
          if (div_q) begin
            lo_d = neg_lo_q ? -mq_q : mq_q;
            hi_d = neg_hi_q ? -acc_q : acc_q;
          end else begin
            {hi_d, lo_d} = prod;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      div_q      <= 1'b0;
      acc_q      <= '0;
      mq_q       <= '0;
      opb_q      <= '0;
      cnt_q      <= '0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      acc_q      <= acc_d;
      mq_q       <= mq_d;
      opb_q      <= opb_d;
      cnt_q      <= cnt_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit (FAST_ZERO=1 and =0).
// Edges are numbered with the accepting edge as 1.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic acc_busy, done_busy;

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit_if #(.WIDTH(W)) bus2 ();

  muldiv_unit #(.WIDTH(W), .FAST_ZERO(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  muldiv_unit #(.WIDTH(W), .FAST_ZERO(0)) dut_nz (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int edge_n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk); #1;
    acc_busy = bus.busy;
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.op = 2'($urandom);
    edge_n = -1;
    done_busy = 1'b1;
    for (int i = 2; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        edge_n = i;
        done_busy = bus.busy;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    bus.start = 1'b1;
    bus.op = OP_MULT;
    bus.a = 32'd3;
    bus.b = 32'd4;
    bus2.start = 1'b0;
    bus2.op = OP_MULT;
    bus2.a = '0;
    bus2.b = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      failures++; $display("FAIL reset_done: got %b want 0", bus.done);
    end
    checks++;
    if (bus.div_zero !== 1'b0) begin
      failures++; $display("FAIL reset_dz: got %b want 0", bus.div_zero);
    end
    checks++;
    if ({bus.hi, bus.lo} !== 64'h0) begin
      failures++; $display("FAIL reset_hilo: got %h_%h want 0", bus.hi, bus.lo);
    end
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult;
    int e;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'h00000007, e);
    checks++;
    if (e !== 34) begin
      failures++; $display("FAIL mult_latency: got edge %0d want 34", e);
    end
    checks++;
    if (acc_busy !== 1'b1) begin
      failures++; $display("FAIL mult_busy_accept: got %b want 1", acc_busy);
    end
    checks++;
    if (done_busy !== 1'b0) begin
      failures++; $display("FAIL mult_busy_done: got %b want 0", done_busy);
    end
    checks++;
    if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFEB) begin
      failures++;
      $display("FAIL mult: got %h_%h want FFFFFFFF_FFFFFFEB", bus.hi, bus.lo);
    end
  endtask

  task automatic test_multu;
    int e;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, e);
    checks++;
    if (e !== 34 || bus.hi !== 32'hFFFFFFFE || bus.lo !== 32'h00000001) begin
      failures++;
      $display("FAIL multu: got e=%0d %h_%h want e=34 FFFFFFFE_00000001",
               e, bus.hi, bus.lo);
    end
  endtask

  task automatic test_div_signed;
    int e;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, e);
    checks++;
    if (e !== 34 || bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL div_neg_a: got e=%0d q=%h r=%h want e=34 q=FFFFFFFD r=FFFFFFFF",
               e, bus.lo, bus.hi);
    end
    run_op(OP_DIV, 32'h00000007, 32'hFFFFFFFE, e);
    checks++;
    if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'h00000001) begin
      failures++;
      $display("FAIL div_neg_b: got q=%h r=%h want q=FFFFFFFD r=00000001",
               bus.lo, bus.hi);
    end
  endtask

  task automatic test_div_min;
    int e;
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, e);
    checks++;
    if (bus.lo !== 32'h80000000 || bus.hi !== 32'h0 || bus.div_zero !== 1'b0) begin
      failures++;
      $display("FAIL div_min: got q=%h r=%h dz=%b want q=80000000 r=0 dz=0",
               bus.lo, bus.hi, bus.div_zero);
    end
  endtask

  task automatic test_divu;
    int e;
    run_op(OP_DIVU, 32'd100, 32'd7, e);
    checks++;
    if (e !== 34 || bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      failures++;
      $display("FAIL divu: got e=%0d q=%h r=%h want e=34 q=e r=2", e, bus.lo, bus.hi);
    end
  endtask

  task automatic test_div_zero_fast;
    int e;
    run_op(OP_DIVU, 32'd100, 32'd0, e);
    checks++;
    if (e !== 2) begin
      failures++; $display("FAIL dz_fast_latency: got edge %0d want 2", e);
    end
    checks++;
    if (bus.div_zero !== 1'b1) begin
      failures++; $display("FAIL dz_fast_flag: got %b want 1", bus.div_zero);
    end
    checks++;
    if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      failures++;
      $display("FAIL dz_fast_hold: got q=%h r=%h want q=e r=2", bus.lo, bus.hi);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.div_zero !== 1'b1) begin
      failures++; $display("FAIL dz_fast_sticky: got %b want 1", bus.div_zero);
    end
    run_op(OP_MULTU, 32'd6, 32'd7, e);
    checks++;
    if (bus.div_zero !== 1'b0 || bus.lo !== 32'd42 || bus.hi !== 32'd0) begin
      failures++;
      $display("FAIL dz_clear: got dz=%b %h_%h want dz=0 0_2a",
               bus.div_zero, bus.hi, bus.lo);
    end
  endtask

  task automatic test_div_zero_slow;
    int e;
    @(negedge clk);
    bus2.start = 1'b1;
    bus2.op = OP_DIV;
    bus2.a = 32'hFFFFFFFB;
    bus2.b = 32'h0;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    bus2.a = 32'h12345678;
    e = -1;
    for (int i = 2; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus2.done) begin
        e = i;
        break;
      end
    end
    checks++;
    if (e !== 34 || bus2.div_zero !== 1'b1) begin
      failures++;
      $display("FAIL dz_slow: got e=%0d dz=%b want e=34 dz=1", e, bus2.div_zero);
    end
    checks++;
    if (bus2.lo !== 32'hFFFFFFFF || bus2.hi !== 32'hFFFFFFFB) begin
      failures++;
      $display("FAIL dz_slow_val: got q=%h r=%h want q=FFFFFFFF r=FFFFFFFB",
               bus2.lo, bus2.hi);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int nd;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = OP_MULTU;
    bus.a = 32'd5;
    bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid: got busy=%b %h_%h want busy=0 0_0",
               bus.busy, bus.hi, bus.lo);
    end
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) nd++;
    end
    checks++;
    if (nd !== 0) begin
      failures++; $display("FAIL reset_mid_done: got %0d pulses want 0", nd);
    end
  endtask

  task automatic test_back_to_back;
    int nd;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = OP_MULTU;
    bus.a = 32'd3;
    bus.b = 32'd5;
    @(posedge clk); #1;
    bus.op = OP_DIVU;
    bus.a = 32'd9;
    bus.b = 32'd9;
    nd = 0;
    seen = 1'b0;
    for (int i = 2; i <= 100 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        seen = 1'b1;
        nd++;
      end
    end
    checks++;
    if (!seen || bus.hi !== 32'd0 || bus.lo !== 32'd15) begin
      failures++;
      $display("FAIL b2b_result: got seen=%b %h_%h want seen=1 0_f",
               seen, bus.hi, bus.lo);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL b2b_done_start: got busy=%b want 0", bus.busy);
    end
    bus.start = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) nd++;
    end
    checks++;
    if (nd !== 1) begin
      failures++; $display("FAIL b2b_pulses: got %0d want 1", nd);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div_signed();
    test_div_min();
    test_divu();
    test_div_zero_fast();
    test_div_zero_slow();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal range 8..64, even).
REQ-002 SHALL have parameter FAST_ZERO, default 1; when 1, divide-by-zero completes without iterating.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: clk  input  1  rising-edge clock.
REQ-005 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-007 SHALL have port: op  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-008 SHALL have port: a  input  WIDTH  multiplicand or dividend.
REQ-009 SHALL have port: b  input  WIDTH  multiplier or divisor.
REQ-010 SHALL have port: hi  output  WIDTH  upper product half, or remainder.
REQ-011 SHALL have port: lo  output  WIDTH  lower product half, or quotient.
REQ-012 SHALL have port: busy  output  1  high from the accepting edge until done.
REQ-013 SHALL have port: done  output  1  single-cycle completion pulse.
REQ-014 SHALL have port: div_zero  output  1  set with done when a DIV/DIVU divisor is 0; held until the next accept.

Function
REQ-015 SHALL implement the states IDLE, RUN and FINISH.
REQ-016 IDLE SHALL go to RUN on start=1: latch op, latch |a| and |b| (signed ops) or a and b, latch the result-sign flags, clear the iteration counter, set busy=1 and clear div_zero.
REQ-017 RUN SHALL perform one radix-2 iteration per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-018 RUN SHALL last exactly WIDTH cycles and SHALL then go to FINISH.
REQ-019 FINISH SHALL apply sign correction, load hi/lo, pulse done=1 for one cycle, clear busy and return to IDLE.
REQ-020 Latency SHALL be WIDTH+2 edges from the accepting edge to the edge that raises done; for WIDTH=32 this is 34.
REQ-021 Signed divide SHALL truncate the quotient toward zero, with the remainder taking the sign of the dividend.
REQ-022 Signed multiply SHALL produce the 2*WIDTH two's-complement product, split across {hi,lo}.
REQ-023 Divide of minimum-negative by -1 SHALL give lo=minimum-negative and hi=0, with no flag raised.
REQ-024 With FAST_ZERO=1, a DIV/DIVU with b=0 SHALL go directly to FINISH: done follows 2 edges after acceptance, div_zero=1, hi and lo unchanged.
REQ-025 With FAST_ZERO=0, a divide by zero SHALL run the full latency and yield lo=all-ones and hi=a; div_zero SHALL still be 1.
REQ-026 start, op, a and b SHALL be ignored while busy=1, and a and b MAY change after acceptance.
REQ-027 hi and lo SHALL hold their value between completions; they SHALL update only in FINISH.
REQ-028 start=1 in the same cycle as done=1 SHALL be ignored; a new request SHALL be accepted no earlier than the next IDLE cycle.

Reset
REQ-029 reset=1 SHALL force IDLE and clear hi, lo, busy, done, div_zero, the counter and all internal registers on the next edge.
REQ-030 Reset mid-operation SHALL abort the operation with no done pulse, and reset SHALL take priority over start.

Structure
REQ-031 A shared package muldiv_pkg SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the state encoding.
REQ-032 One sub-module, muldiv_step (combinational: a single shift-add or shift-subtract iteration, parametrised on WIDTH), SHALL be instantiated once.
REQ-033 The counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL not wrap during RUN.

Verification
REQ-034 WIDTH=32, MULT a=FFFFFFFD, b=00000007 -> done at edge 34, hi=FFFFFFFF, lo=FFFFFFEB.
REQ-035 MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-036 DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000, div_zero=0.
REQ-037 DIVU a=100, b=0 with FAST_ZERO=1 -> done 2 edges after accept, div_zero=1, hi/lo keep their previous values.
REQ-038 reset asserted at RUN iteration 10 -> busy=0, hi=lo=0 on the next edge, and no done pulse follows.
REQ-039 start pulsed with different operands while busy -> result matches the first operands, and exactly one done pulse occurs.
